// File: rtl/jbi_min_rq_rdq_fifo.sv
// jbi_min_rq_rdq_fifo: request data queue for the JBI min block.
// Holds WDQ write data until the request issuer drains it. Single clock,
// registered read data with one-cycle latency, occupancy-based status and
// sticky overflow/underflow flags.
// Optional macro JBI_RDQ_PARITY_EN: adds a per-entry even-parity bit, the
// par_inj input (parity corruption on push) and the sticky par_err output.
module jbi_min_rq_rdq_fifo #(
    parameter int unsigned WIDTH        = 156,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned ADDR_WIDTH   = 4,
    parameter int unsigned AFULL_THRESH = 14
) (
    input  logic                  clk,
    input  logic                  arst_l,
    input  logic                  push,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  pop,
    output logic [WIDTH-1:0]      rdata,
    output logic                  rdata_vld,
    output logic                  full,
    output logic                  afull,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    input  logic                  err_clr,
    output logic                  ovf_err,
`ifdef JBI_RDQ_PARITY_EN
    output logic                  udf_err,
    input  logic                  par_inj,
    output logic                  par_err
`else
    output logic                  udf_err
`endif
);

`ifdef JBI_RDQ_PARITY_EN
    localparam int unsigned ENTRY_W = WIDTH + 1;
`else
    localparam int unsigned ENTRY_W = WIDTH;
`endif
    localparam int unsigned CNT_W = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(AFULL_THRESH);

    logic [ENTRY_W-1:0]    mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] rptr;
    logic [ENTRY_W-1:0]    wr_entry;
    logic [ENTRY_W-1:0]    rd_entry;
    logic                  push_ok;
    logic                  pop_ok;
    logic                  ovf_evt;
    logic                  udf_evt;

    // Status decodes straight from the registered occupancy
    assign full  = (count == FULL_CNT);
    assign afull = (count >= AFULL_CNT);
    assign empty = (count == '0);

    // A full queue still takes a push when a pop frees the head this cycle;
    // an empty queue never bypasses, so a same-cycle pop there is rejected
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop);
    assign ovf_evt = push & full & ~pop;
    assign udf_evt = pop & empty;

    assign rd_entry = mem[rptr];

`ifdef JBI_RDQ_PARITY_EN
    // Even parity over the data, optionally corrupted for error injection
    assign wr_entry = {(^wdata) ^ par_inj, wdata};
`else
    assign wr_entry = wdata;
`endif

    // Storage array; deliberately not reset
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr] <= wr_entry;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk or negedge arst_l) begin
        if (!arst_l) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + ADDR_WIDTH'(1);
            end
            if (pop_ok) begin
                rptr <= rptr + ADDR_WIDTH'(1);
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Read data register; holds its value between accepted pops
    always_ff @(posedge clk or negedge arst_l) begin
        if (!arst_l) begin
            rdata     <= '0;
            rdata_vld <= 1'b0;
        end else begin
            rdata_vld <= pop_ok;
            if (pop_ok) begin
                rdata <= rd_entry[WIDTH-1:0];
            end
        end
    end

    // Sticky error flags; a new error event beats a coincident clear
    always_ff @(posedge clk or negedge arst_l) begin
        if (!arst_l) begin
            ovf_err <= 1'b0;
            udf_err <= 1'b0;
        end else begin
            if (ovf_evt) begin
                ovf_err <= 1'b1;
            end else if (err_clr) begin
                ovf_err <= 1'b0;
            end
            if (udf_evt) begin
                udf_err <= 1'b1;
            end else if (err_clr) begin
                udf_err <= 1'b0;
            end
        end
    end

`ifdef JBI_RDQ_PARITY_EN
    // Parity check on the popped entry, visible alongside rdata_vld
    always_ff @(posedge clk or negedge arst_l) begin
        if (!arst_l) begin
            par_err <= 1'b0;
        end else if (pop_ok && (^rd_entry)) begin
            par_err <= 1'b1;
        end else if (err_clr) begin
            par_err <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_jbi_min_rq_rdq_fifo.sv
// tb_jbi_min_rq_rdq_fifo: self-checking bench for jbi_min_rq_rdq_fifo.
// Directed scenarios plus randomized traffic against a queue-based model.
// Define JBI_RDQ_PARITY_EN for both files to exercise the parity option.
module tb_jbi_min_rq_rdq_fifo;

    localparam int unsigned W     = 156;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;
    localparam int unsigned AFT   = 14;

    logic          clk;
    logic          arst_l;
    logic          push;
    logic [W-1:0]  wdata;
    logic          pop;
    logic [W-1:0]  rdata;
    logic          rdata_vld;
    logic          full;
    logic          afull;
    logic          empty;
    logic [AW:0]   count;
    logic          err_clr;
    logic          ovf_err;
    logic          udf_err;
    logic          par_inj;
`ifdef JBI_RDQ_PARITY_EN
    logic          par_err;
`endif

    int errors;
    int checks;

    // Behavioural model: the queue contents plus expected registered outputs
    logic [W-1:0] q   [$];
    logic         qi  [$];
    logic [W-1:0] exp_rdata;
    logic         exp_vld;
    logic         exp_ovf;
    logic         exp_udf;
    logic         exp_par;

    jbi_min_rq_rdq_fifo #(
        .WIDTH(W), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .AFULL_THRESH(AFT)
    ) dut (
        .clk(clk),
        .arst_l(arst_l),
        .push(push),
        .wdata(wdata),
        .pop(pop),
        .rdata(rdata),
        .rdata_vld(rdata_vld),
        .full(full),
        .afull(afull),
        .empty(empty),
        .count(count),
        .err_clr(err_clr),
        .ovf_err(ovf_err),
`ifdef JBI_RDQ_PARITY_EN
        .udf_err(udf_err),
        .par_inj(par_inj),
        .par_err(par_err)
`else
        .udf_err(udf_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] rnd_word();
        logic [159:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return r[W-1:0];
    endfunction

    task automatic model_clear();
        q.delete();
        qi.delete();
        exp_rdata = '0;
        exp_vld   = 1'b0;
        exp_ovf   = 1'b0;
        exp_udf   = 1'b0;
        exp_par   = 1'b0;
    endtask

    // One clock: apply the queue rules to the model, then release the strobes
    task automatic cyc();
        bit was_full;
        bit was_empty;
        bit pop_acc;
        bit push_acc;
        bit bad;
        @(posedge clk);
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        pop_acc   = pop && !was_empty;
        push_acc  = push && (!was_full || pop);
        bad       = 1'b0;
        exp_vld   = pop_acc;
        if (pop_acc) begin
            exp_rdata = q.pop_front();
            bad       = qi.pop_front();
        end
        if (push_acc) begin
            q.push_back(wdata);
            qi.push_back(par_inj);
        end
        if (push && was_full && !pop) exp_ovf = 1'b1;
        else if (err_clr)             exp_ovf = 1'b0;
        if (pop && was_empty)         exp_udf = 1'b1;
        else if (err_clr)             exp_udf = 1'b0;
        if (bad)                      exp_par = 1'b1;
        else if (err_clr)             exp_par = 1'b0;
        #1;
        push    = 1'b0;
        pop     = 1'b0;
        err_clr = 1'b0;
        par_inj = 1'b0;
    endtask

    task automatic test_reset();
        arst_l = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (count !== '0)       begin errors++; $display("FAIL rst_count: got %0d want 0", count); end
        checks++; if (empty !== 1'b1)     begin errors++; $display("FAIL rst_empty: got %b want 1", empty); end
        checks++; if ({full, afull} !== 2'b00) begin errors++; $display("FAIL rst_full_afull: got %b want 00", {full, afull}); end
        checks++; if (rdata !== '0 || rdata_vld !== 1'b0) begin errors++; $display("FAIL rst_rdata: got %h/%b want 0/0", rdata, rdata_vld); end
        checks++; if ({ovf_err, udf_err} !== 2'b00) begin errors++; $display("FAIL rst_errs: got %b want 00", {ovf_err, udf_err}); end
        arst_l = 1'b1;
        model_clear();
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= 16; i++) begin
            push = 1'b1; wdata = W'(i);
            cyc();
            checks++; if (count !== (AW+1)'(i)) begin errors++; $display("FAIL fill_count: got %0d want %0d", count, i); end
            checks++; if (afull !== (i >= 14)) begin errors++; $display("FAIL fill_afull: n=%0d got %b want %b", i, afull, (i >= 14)); end
            checks++; if (full !== (i == 16)) begin errors++; $display("FAIL fill_full: n=%0d got %b want %b", i, full, (i == 16)); end
        end
        for (int i = 1; i <= 16; i++) begin
            pop = 1'b1;
            cyc();
            checks++; if (rdata !== W'(i) || rdata_vld !== 1'b1) begin errors++; $display("FAIL drain_rdata: got %h/%b want %h/1", rdata, rdata_vld, W'(i)); end
        end
        cyc();
        checks++; if (rdata_vld !== 1'b0 || rdata !== W'(16)) begin errors++; $display("FAIL drain_hold: got %h/%b want 10/0", rdata, rdata_vld); end
        checks++; if (empty !== 1'b1 || count !== '0) begin errors++; $display("FAIL drain_empty: got %b/%0d want 1/0", empty, count); end
    endtask

    task automatic test_full_push_pop();
        for (int i = 1; i <= 16; i++) begin
            push = 1'b1; wdata = W'(i);
            cyc();
        end
        push = 1'b1; pop = 1'b1; wdata = W'('hAA);
        cyc();
        checks++; if (rdata !== W'(1) || rdata_vld !== 1'b1) begin errors++; $display("FAIL fpp_rdata: got %h/%b want 1/1", rdata, rdata_vld); end
        checks++; if (count !== 5'd16 || ovf_err !== 1'b0) begin errors++; $display("FAIL fpp_count_ovf: got %0d/%b want 16/0", count, ovf_err); end
        for (int i = 0; i < 16; i++) begin
            pop = 1'b1;
            cyc();
            checks++; if (rdata !== exp_rdata) begin errors++; $display("FAIL fpp_drain: got %h want %h", rdata, exp_rdata); end
        end
        checks++; if (rdata !== W'('hAA) || empty !== 1'b1) begin errors++; $display("FAIL fpp_wrap: got %h/%b want aa/1", rdata, empty); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 16; i++) begin
            push = 1'b1; wdata = W'(i + 'h40);
            cyc();
        end
        push = 1'b1; wdata = W'('hBB);
        cyc();
        checks++; if (ovf_err !== 1'b1 || count !== 5'd16) begin errors++; $display("FAIL ovf_set: got %b/%0d want 1/16", ovf_err, count); end
        push = 1'b1; wdata = W'('hBB); err_clr = 1'b1;
        cyc();
        checks++; if (ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_clr_collide: got %b want 1", ovf_err); end
        err_clr = 1'b1;
        cyc();
        checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL ovf_clr: got %b want 0", ovf_err); end
        for (int i = 0; i < 16; i++) begin
            pop = 1'b1;
            cyc();
            checks++; if (rdata !== W'(i + 'h40)) begin errors++; $display("FAIL ovf_drain: got %h want %h", rdata, W'(i + 'h40)); end
        end
    endtask

    task automatic test_underflow();
        push = 1'b1; pop = 1'b1; wdata = W'(5);
        cyc();
        checks++; if (rdata_vld !== 1'b0 || udf_err !== 1'b1 || count !== 5'd1) begin errors++; $display("FAIL udf_same_cycle: got vld=%b udf=%b cnt=%0d want 0/1/1", rdata_vld, udf_err, count); end
        pop = 1'b1;
        cyc();
        checks++; if (rdata !== W'(5) || rdata_vld !== 1'b1) begin errors++; $display("FAIL udf_next_pop: got %h/%b want 5/1", rdata, rdata_vld); end
        pop = 1'b1;
        cyc();
        checks++; if (rdata_vld !== 1'b0 || rdata !== W'(5)) begin errors++; $display("FAIL udf_empty_pop: got %h/%b want 5/0", rdata, rdata_vld); end
        pop = 1'b1; err_clr = 1'b1;
        cyc();
        checks++; if (udf_err !== 1'b1) begin errors++; $display("FAIL udf_clr_collide: got %b want 1", udf_err); end
        err_clr = 1'b1;
        cyc();
        checks++; if (udf_err !== 1'b0) begin errors++; $display("FAIL udf_clr: got %b want 0", udf_err); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 8; i++) begin
            push = 1'b1; wdata = rnd_word();
            cyc();
        end
        pop = 1'b1;
        cyc();
        arst_l = 1'b0;
        #1;
        checks++; if (count !== '0 || empty !== 1'b1 || rdata !== '0 || rdata_vld !== 1'b0) begin errors++; $display("FAIL mid_reset: got cnt=%0d empty=%b rdata=%h vld=%b", count, empty, rdata, rdata_vld); end
        @(posedge clk);
        #1;
        arst_l = 1'b1;
        model_clear();
        push = 1'b1; wdata = W'('h77);
        cyc();
        pop = 1'b1;
        cyc();
        checks++; if (rdata !== W'('h77) || rdata_vld !== 1'b1 || empty !== 1'b1) begin errors++; $display("FAIL mid_reset_after: got %h/%b/%b want 77/1/1", rdata, rdata_vld, empty); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            int pp;
            pp      = (n < 300) ? 75 : 30;
            push    = ($urandom_range(99) < pp);
            pop     = ($urandom_range(99) < 50);
            err_clr = ($urandom_range(99) < 8);
            wdata   = rnd_word();
            cyc();
            checks++; if (count !== (AW+1)'(q.size())) begin errors++; $display("FAIL rnd_count @%0d: got %0d want %0d", n, count, q.size()); end
            checks++; if ({full, afull, empty} !== {q.size() == DEPTH, q.size() >= AFT, q.size() == 0}) begin errors++; $display("FAIL rnd_status @%0d: got %b want size %0d", n, {full, afull, empty}, q.size()); end
            checks++; if (rdata !== exp_rdata || rdata_vld !== exp_vld) begin errors++; $display("FAIL rnd_rdata @%0d: got %h/%b want %h/%b", n, rdata, rdata_vld, exp_rdata, exp_vld); end
            checks++; if ({ovf_err, udf_err} !== {exp_ovf, exp_udf}) begin errors++; $display("FAIL rnd_errs @%0d: got %b want %b", n, {ovf_err, udf_err}, {exp_ovf, exp_udf}); end
        end
        while (q.size() != 0) begin
            pop = 1'b1;
            cyc();
        end
        err_clr = 1'b1;
        cyc();
    endtask

`ifdef JBI_RDQ_PARITY_EN
    task automatic test_parity();
        push = 1'b1; wdata = W'(3); par_inj = 1'b1;
        cyc();
        push = 1'b1; wdata = W'(4);
        cyc();
        pop = 1'b1;
        cyc();
        checks++; if (par_err !== 1'b1 || rdata_vld !== 1'b1 || rdata !== W'(3)) begin errors++; $display("FAIL par_detect: got %b/%b/%h want 1/1/3", par_err, rdata_vld, rdata); end
        err_clr = 1'b1;
        cyc();
        checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL par_clr: got %b want 0", par_err); end
        pop = 1'b1;
        cyc();
        checks++; if (par_err !== 1'b0 || rdata !== W'(4)) begin errors++; $display("FAIL par_clean: got %b/%h want 0/4", par_err, rdata); end
        for (int i = 0; i < 40; i++) begin
            push    = ($urandom_range(1) == 1);
            pop     = ($urandom_range(1) == 1);
            par_inj = ($urandom_range(3) == 0);
            err_clr = ($urandom_range(3) == 0);
            wdata   = rnd_word();
            cyc();
            checks++; if (par_err !== exp_par) begin errors++; $display("FAIL par_rnd @%0d: got %b want %b", i, par_err, exp_par); end
        end
    endtask
`endif

    initial begin
        errors  = 0;
        checks  = 0;
        push    = 1'b0;
        pop     = 1'b0;
        err_clr = 1'b0;
        par_inj = 1'b0;
        wdata   = '0;
        arst_l  = 1'b0;
        model_clear();
        test_reset();
        test_fill_drain();
        test_full_push_pop();
        test_overflow();
        test_underflow();
        test_reset_mid();
        test_random();
`ifdef JBI_RDQ_PARITY_EN
        test_parity();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
